// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command arbiter: command word layout,
// FSM state encodings and default timing constants.
package i2c_pkg;

    // Command word: {valid, len[3:0], addr[6:0], rw, payload[23:0]}
    localparam int CMDW        = 37;
    localparam int VALID_BIT   = 36;
    localparam int LEN_LSB     = 32;
    localparam int LEN_W       = 4;
    localparam int ADDR_LSB    = 25;
    localparam int ADDR_W      = 7;
    localparam int RW_BIT      = 24;
    localparam int PAYLOAD_LSB = 0;
    localparam int PAYLOAD_W   = 24;

    // Cycles after a forwarded start before the master's busy flag is trusted
    localparam int SETTLE_DEF  = 5;

    // Arbiter FSM states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ARB      = 3'd1;
    localparam logic [2:0] ST_OWN      = 3'd2;
    localparam logic [2:0] ST_SETTLE_W = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;

    // Packs the command fields into one master command word
    function automatic logic [CMDW-1:0] pack_cmd(
        input logic [LEN_W-1:0]     len,
        input logic [ADDR_W-1:0]    addr,
        input logic                 rw,
        input logic [PAYLOAD_W-1:0] payload
    );
        pack_cmd = {1'b1, len, addr, rw, payload};
    endfunction

endpackage

// File: rtl/i2c_cmd_arbiter_rr.sv
// Combinational round-robin picker: searches upward from ptr_i+1 (wrapping)
// and returns the first requester found as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [2:0]   ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [2:0]   idx_o,
    output logic         any_o
);

    // Scan from the farthest candidate down to ptr+1 so the nearest one wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = N; k >= 1; k--) begin
            int j;
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = 3'(j);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C master command port among NREQ clients, granting whole
// multi-command sessions atomically with round-robin fairness.
// Optional hold watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_cmd_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int CMDW     = i2c_pkg::CMDW,
    parameter int SETTLE   = i2c_pkg::SETTLE_DEF,
    parameter int HOLD_MAX = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    input  logic [NREQ*CMDW-1:0] cmd_in,
    input  logic [NREQ-1:0]      start_in,
    output logic [NREQ-1:0]      busy_out,
    output logic [CMDW-1:0]      i2ccmd,
    output logic                 i2cstart,
    input  logic                 i2cbusy,
    output logic [2:0]           owner,
    output logic                 timeout
);

    if (NREQ < 2 || NREQ > 8 || HOLD_MAX < 1 || HOLD_MAX > 65535) begin : g_bad_cfg
        $error("i2c_cmd_arbiter: parameter out of range");
    end

    localparam int              CNTW     = $clog2(SETTLE + 2);
    localparam logic [CNTW-1:0] SETTLE_C = CNTW'(SETTLE);

    logic [2:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [2:0]      owner_q, owner_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [CMDW-1:0] cmd_q, cmd_d;
    logic            start_q, start_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [NREQ-1:0] arb_gnt;
    logic [2:0]      arb_idx;
    logic            arb_any;

    logic            own_req, own_start;
    logic [CMDW-1:0] own_cmd;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_C = 16'(HOLD_MAX - 1);
    logic [15:0] hold_q, hold_d;
    logic [15:0] bsy_q, bsy_d;
    logic        timeout_q, timeout_d;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    rr_arbiter #(.N(NREQ)) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Route the current owner's request, start and command to the FSM
    always_comb begin
        own_req   = 1'b0;
        own_start = 1'b0;
        own_cmd   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == 3'(i)) begin
                own_req   = req[i];
                own_start = start_in[i];
                own_cmd   = cmd_in[i*CMDW +: CMDW];
            end
        end
    end

    // Non-owners always see busy; the owner sees the master as if directly attached
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            busy_out[i] = gnt_q[i] ? (i2cbusy | (state_q != ST_OWN) | start_q) : 1'b1;
        end
    end

    // Session FSM: arbitrate, forward owner starts, wait out busy lag, drain
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cmd_d   = cmd_q;
        start_d = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (arb_any) begin
                    gnt_d   = arb_gnt;
                    owner_d = arb_idx;
                    ptr_d   = arb_idx;
                    state_d = ST_OWN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN: begin
                cmd_d = own_cmd;
                // A start that coincides with req dropping is still forwarded
                if (own_start && !i2cbusy) begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE_W;
                end else if (!own_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_SETTLE_W: begin
                if (cnt_q <= SETTLE_C) cnt_d = cnt_q + CNTW'(1);
                if (cnt_q > SETTLE_C && !i2cbusy) state_d = own_req ? ST_OWN : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!i2cbusy) begin
                    gnt_d   = '0;
                    cmd_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef I2C_ARB_TIMEOUT_EN
        timeout_d = timeout_q;
        hold_d    = (|gnt_q) ? hold_q + 16'd1 : 16'd0;
        bsy_d     = ((state_q == ST_SETTLE_W || state_q == ST_DRAIN) && i2cbusy) ? bsy_q + 16'd1 : 16'd0;
        // Pointer already sits on the offender, so the next round skips past it
        if (|gnt_q && (hold_q == HOLD_C || bsy_q == HOLD_C)) begin
            gnt_d     = '0;
            cmd_d     = '0;
            start_d   = 1'b0;
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
            hold_d    = 16'd0;
            bsy_d     = 16'd0;
        end
`endif
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            cmd_q     <= '0;
            start_q   <= 1'b0;
            cnt_q     <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            hold_q    <= '0;
            bsy_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cmd_q     <= cmd_d;
            start_q   <= start_d;
            cnt_q     <= cnt_d;
`ifdef I2C_ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            bsy_q     <= bsy_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign i2ccmd   = cmd_q;
    assign i2cstart = start_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Scoreboard bench for i2c_cmd_arbiter: behavioural clients, a simple
// I2C master busy model and a round-robin reference for grant order.
module tb_i2c_cmd_arbiter;

    localparam int NREQ    = 4;
    localparam int CMDW    = 37;
    localparam int SETTLE  = 5;
    localparam int HOLD_TB = 400;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req, gnt, start_in, busy_out;
    logic [NREQ*CMDW-1:0] cmd_in;
    logic [CMDW-1:0]      i2ccmd;
    logic                 i2cstart, i2cbusy, timeout;
    logic [2:0]           owner;

    always #5 clk = ~clk;

    i2c_cmd_arbiter #(.NREQ(NREQ), .CMDW(CMDW), .SETTLE(SETTLE), .HOLD_MAX(HOLD_TB)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .cmd_in(cmd_in),
        .start_in(start_in), .busy_out(busy_out), .i2ccmd(i2ccmd),
        .i2cstart(i2cstart), .i2cbusy(i2cbusy), .owner(owner), .timeout(timeout)
    );

    typedef struct { int idx; logic [CMDW-1:0] cmd; } exp_t;
    exp_t sb[$];

    int n_vec = 0, n_err = 0;
    int cyc = 0, last_start = -1, n_start = 0, n_gr = 0, ptr_m = 0;
    logic [NREQ-1:0] prev_gnt = '0;
    int left[NREQ], sess[NREQ], ncmd[NREQ], seq[NREQ];
    bit noisy[NREQ];
    int lag = 0, blen = 20, m_t = 0;
    bit m_active = 0, stuck = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [CMDW-1:0] mk(input int i, input int s);
        mk = {1'b1, 4'd1, 7'h74, 1'b0, 8'(i), 16'(s)};
    endfunction

    function automatic int rr(input logic [NREQ-1:0] r, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (p + k) % NREQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit all_idle();
        for (int i = 0; i < NREQ; i++) if (sess[i] != 0) return 0;
        return (req == '0) && (gnt == '0) && (sb.size() == 0) && !m_active;
    endfunction

    // One clock: check outputs, advance master model, then let clients act
    task automatic step();
        exp_t e;
        int w;
        @(negedge clk);
        cyc++;
        if (i2cstart) begin
            n_start++;
            chk("start_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("i2ccmd", 64'(i2ccmd), 64'(e.cmd));
                chk("start_gnt", 64'(gnt), 64'd1 << e.idx);
            end
            if (last_start >= 0) chk("start_gap", 64'((cyc - last_start) > SETTLE + 1), 64'd1);
            last_start = cyc;
        end
        if (prev_gnt == '0 && gnt != '0) begin
            n_gr++;
            w = rr(req, ptr_m);
            chk("gnt_rr", 64'(gnt), (w < 0) ? 64'd0 : (64'd1 << w));
            chk("owner", 64'(owner), (w < 0) ? 64'd0 : 64'(w));
            if (!stuck) chk("gnt_bus_idle", 64'(i2cbusy), 64'd0);
            if (w >= 0) ptr_m = w;
        end
        chk("busy_ngnt", 64'(busy_out | gnt), 64'({NREQ{1'b1}}));
        if (gnt != '0 && i2cbusy) chk("busy_own", 64'(busy_out & gnt), 64'(gnt));
        prev_gnt = gnt;

        if (i2cstart) begin
            m_active = 1;
            m_t = 0;
        end else if (m_active) begin
            m_t++;
            if (m_t >= lag + blen) m_active = 0;
        end
        i2cbusy = stuck | (m_active && m_t >= lag && m_t < lag + blen);
        #1;

        for (int i = 0; i < NREQ; i++) begin
            start_in[i] = 1'b0;
            if (!rst) begin
                if (noisy[i] && !gnt[i] && sess[i] > 0) begin
                    start_in[i] = 1'b1;
                    cmd_in[i*CMDW +: CMDW] = {1'b1, 4'hF, 7'h55, 1'b1, 24'hDEAD00 | 24'(i)};
                end
                if (req[i]) begin
                    if (gnt[i] && !busy_out[i]) begin
                        if (left[i] > 0) begin
                            start_in[i] = 1'b1;
                            cmd_in[i*CMDW +: CMDW] = mk(i, seq[i]);
                            e.idx = i;
                            e.cmd = mk(i, seq[i]);
                            sb.push_back(e);
                            left[i]--;
                            seq[i]++;
                        end else begin
                            req[i] = 1'b0;
                            sess[i]--;
                        end
                    end
                end else if (sess[i] > 0) begin
                    req[i]  = 1'b1;
                    left[i] = ncmd[i];
                end
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done;
        done = 0;
        for (int k = 0; k < max_cyc; k++) begin
            step();
            if (all_idle()) begin
                done = 1;
                break;
            end
        end
        chk("idle_reached", 64'(done), 64'd1);
    endtask

    initial begin
        int s0, g0;
        bit seen;
        rst = 1'b1; req = '0; start_in = '0; cmd_in = '0; i2cbusy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 0; sess[i] = 0; ncmd[i] = 0; seq[i] = i * 256; noisy[i] = 0;
        end
        step();
        step();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_i2cstart", 64'(i2cstart), 64'd0);
        chk("rst_busy_out", 64'(busy_out), 64'hF);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_i2ccmd", 64'(i2ccmd), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        rst = 1'b0;

        // single client, three commands
        s0 = n_start;
        ncmd[0] = 3; sess[0] = 1;
        wait_idle(2000);
        chk("p1_starts", 64'(n_start - s0), 64'd3);

        // contention: clients 0 and 2, two sessions each
        s0 = n_start; g0 = n_gr;
        ncmd[0] = 2; sess[0] = 2; ncmd[2] = 2; sess[2] = 2;
        wait_idle(4000);
        chk("p2_starts", 64'(n_start - s0), 64'd8);
        chk("p2_grants", 64'(n_gr - g0), 64'd4);

        // atomicity: 9-command session while client 3 hammers start_in
        s0 = n_start;
        ncmd[1] = 9; sess[1] = 1; ncmd[3] = 2; sess[3] = 1; noisy[3] = 1;
        wait_idle(6000);
        noisy[3] = 0;
        chk("p3_starts", 64'(n_start - s0), 64'd11);

        // master raises busy 3 cycles after start
        s0 = n_start;
        lag = 3; blen = 10;
        ncmd[2] = 4; sess[2] = 1;
        wait_idle(2000);
        chk("p4_starts", 64'(n_start - s0), 64'd4);
        lag = 0; blen = 20;

        // reset during SETTLE_W
        ncmd[0] = 3; sess[0] = 1;
        seen = 0;
        for (int k = 0; k < 500 && !seen; k++) begin
            step();
            seen = i2cstart;
        end
        chk("p5_start_seen", 64'(seen), 64'd1);
        rst = 1'b1; req = '0; sess[0] = 0; left[0] = 0; start_in = '0;
        step();
        chk("p5_gnt", 64'(gnt), 64'd0);
        chk("p5_i2cstart", 64'(i2cstart), 64'd0);
        chk("p5_busy_out", 64'(busy_out), 64'hF);
        chk("p5_i2ccmd", 64'(i2ccmd), 64'd0);
        rst = 1'b0; ptr_m = 0; sb.delete();
        step();
        step();
        chk("p5_idle", 64'(gnt), 64'd0);
        wait_idle(200);

        // master busy stuck high while client 1 holds the grant
        stuck = 1;
        ncmd[1] = 1; sess[1] = 1;
        repeat (HOLD_TB - 10) step();
        chk("p6_held", 64'(gnt), 64'h2);
`ifdef I2C_ARB_TIMEOUT_EN
        for (int k = 0; k < 30 && gnt != '0; k++) step();
        chk("p6_drop", 64'(gnt), 64'd0);
        chk("p6_timeout", 64'(timeout), 64'd1);
        req[1] = 1'b0; sess[1] = 0; left[1] = 0;
        repeat (5) step();
        chk("p6_sticky", 64'(timeout), 64'd1);
`else
        repeat (60) step();
        chk("p6_persist", 64'(gnt), 64'h2);
        chk("p6_timeout", 64'(timeout), 64'd0);
`endif
        stuck = 0;
        wait_idle(500);

        rst = 1'b1;
        step();
        chk("end_rst_timeout", 64'(timeout), 64'd0);
        chk("end_rst_gnt", 64'(gnt), 64'd0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
